// File: rtl/knn_driver_pkg.sv
// rtl/knn_driver_pkg.sv - shared state encoding and defaults for the knn driver
package knn_driver_pkg;

  // Defaults shared with the knn core top so both sides agree on readback
  // depth and how long the core needs after end-of-stream.
  localparam int DEF_HW_K      = 10;
  localparam int DEF_FLUSH_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_FINISH = 3'd3,
    S_FLUSH  = 3'd4,
    S_SEL    = 3'd5,
    S_OUT    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/knn_driver.sv
// rtl/knn_driver.sv - streams training points into the knn core and reads back neighbour indices
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request, only honoured in IDLE
//   n_points          number of training points to stream (latched on start)
//   solver_sel        solver to read back (latched on start)
//   busy, done        run in progress / one-cycle completion pulse
//   mem_en, mem_addr  synchronous memory read request
//   mem_rdata         read data, one cycle after mem_en
//   knn_data_2        training point to the core (mem_rdata passed through)
//   knn_valid         training point valid
//   knn_done          end-of-stream pulse to the core
//   knn_sel           neighbour rank select to the core
//   knn_solver_sel    solver select to the core
//   knn_data_out      neighbour index returned by the core
//   res_valid/res_ready/res_idx/res_data  result handshake port
module knn_driver
  import knn_driver_pkg::*;
#(
  parameter int W         = 32,
  parameter int HW_K      = DEF_HW_K,
  parameter int N_SOLVERS = 2,
  parameter int ADDR_W    = 16,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       n_points,
  input  logic [W/2-1:0]          solver_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [W-1:0]            mem_rdata,
  output logic [W-1:0]            knn_data_2,
  output logic                    knn_valid,
  output logic                    knn_done,
  output logic [15:0]             knn_sel,
  output logic [W/2-1:0]          knn_solver_sel,
  input  logic [W/2-1:0]          knn_data_out,
  output logic                    res_valid,
  output logic [$clog2(HW_K)-1:0] res_idx,
  output logic [W/2-1:0]          res_data,
  input  logic                    res_ready
);

  localparam int RANK_W  = $clog2(HW_K);
  localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);

  localparam logic [RANK_W-1:0]  LAST_RANK  = RANK_W'(HW_K - 1);
  localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_CYC - 1);

  // A core without solvers has nothing to read back; the select is passed
  // through regardless, so no logic depends on the solver count.
  if (N_SOLVERS < 1) begin : g_no_solvers
  end

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [ADDR_W-1:0]   n_lat;
  logic [W/2-1:0]      solver_lat;
  logic [RANK_W-1:0]   rank;
  logic [FLUSH_W-1:0]  flush_cnt;

  logic addr_last;
  logic flush_last;
  logic rank_last;

  // Counter stops at n_points-1, so the maximum point count never wraps.
  assign addr_last  = (addr_cnt == n_lat - ADDR_W'(1));
  assign flush_last = (flush_cnt == LAST_FLUSH);
  assign rank_last  = (rank == LAST_RANK);

  assign knn_data_2     = mem_rdata;
  assign knn_solver_sel = solver_lat;
  assign mem_addr       = addr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      n_lat      <= '0;
      solver_lat <= '0;
      rank       <= '0;
      flush_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      knn_valid  <= 1'b0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_data   <= '0;
    end else begin
      state     <= state_nx;
      // Memory answers one cycle after the request, so valid trails mem_en.
      knn_valid <= mem_en;
      done      <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat      <= n_points;
            solver_lat <= solver_sel;
            addr_cnt   <= '0;
            rank       <= '0;
            flush_cnt  <= '0;
            busy       <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!addr_last) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt + FLUSH_W'(1);
        end
        S_SEL: begin
          // knn_sel has been stable for this whole cycle; take the core's answer.
          res_data  <= knn_data_out;
          res_idx   <= rank;
          res_valid <= 1'b1;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!rank_last) begin
              rank <= rank + RANK_W'(1);
            end
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    knn_done = 1'b0;
    knn_sel  = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (n_points == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_en = 1'b1;
        if (addr_last) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Last point is on the bus this cycle; knn_done must not overlap it.
        state_nx = S_FINISH;
      end
      S_FINISH: begin
        knn_done = 1'b1;
        state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_last) begin
          state_nx = S_SEL;
        end
      end
      S_SEL: begin
        knn_sel  = 16'(rank);
        state_nx = S_OUT;
      end
      S_OUT: begin
        knn_sel = 16'(rank);
        if (res_ready) begin
          state_nx = rank_last ? S_DONE : S_SEL;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_knn_driver.sv
// tb/tb_knn_driver.sv - randomized self-checking bench for knn_driver
module tb_knn_driver;

  localparam int W         = 32;
  localparam int HW_K      = 10;
  localparam int N_SOLVERS = 2;
  localparam int ADDR_W    = 16;
  localparam int FLUSH_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] n_points;
  logic [W/2-1:0]    solver_sel;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_rdata;
  logic [W-1:0]      knn_data_2;
  logic              knn_valid;
  logic              knn_done;
  logic [15:0]       knn_sel;
  logic [W/2-1:0]    knn_solver_sel;
  logic [W/2-1:0]    knn_data_out;
  logic              res_valid;
  logic [3:0]        res_idx;
  logic [W/2-1:0]    res_data;
  logic              res_ready;

  logic [W-1:0] mem [0:255];
  logic [15:0]  core_base;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  knn_driver #(
    .W(W), .HW_K(HW_K), .N_SOLVERS(N_SOLVERS), .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points), .solver_sel(solver_sel),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .knn_data_2(knn_data_2), .knn_valid(knn_valid), .knn_done(knn_done), .knn_sel(knn_sel),
    .knn_solver_sel(knn_solver_sel), .knn_data_out(knn_data_out), .res_valid(res_valid),
    .res_idx(res_idx), .res_data(res_data), .res_ready(res_ready)
  );

  // Synchronous read memory and a stub core answering base + rank.
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[7:0]];
  assign knn_data_out = core_base + knn_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // rmode: 0 ready always high, 1 stall 3 cycles on rank 2, 2 random ready.
  task automatic do_run(input int n, input logic [15:0] sol, input int rmode, input bit disturb);
    logic [W-1:0] exp_pts[$];
    logic [15:0]  exp_data;
    logic [15:0]  prev_rd;
    logic [3:0]   prev_ri;
    logic         prev_mem_en, prev_rv, prev_xfer, prev_busy;
    int cyc, beats, mem_en_cnt, first_v, last_v, kdone_cnt, kdone_cyc, results, done_cyc;
    int bad_valid, bad_overlap, bad_sel, bad_hold, stall, idx2_cycles, exp_lat;
    for (int i = 0; i < n; i++) exp_pts.push_back(mem[i]);
    beats = 0; mem_en_cnt = 0; first_v = -1; last_v = -1; kdone_cnt = 0; kdone_cyc = -1;
    results = 0; done_cyc = -1; bad_valid = 0; bad_overlap = 0; bad_sel = 0; bad_hold = 0;
    stall = 0; idx2_cycles = 0;
    prev_mem_en = 1'b0; prev_rv = 1'b0; prev_xfer = 1'b0; prev_busy = 1'b0;
    prev_rd = '0; prev_ri = '0;

    @(negedge clk);
    n_points = ADDR_W'(n); solver_sel = sol; start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 3000) begin
      if (disturb && cyc == 2) begin
        start = 1'b1; n_points = ADDR_W'(n + 7); solver_sel = ~sol;
      end else if (disturb && cyc == 3) begin
        start = 1'b0;
      end
      case (rmode)
        0: res_ready = 1'b1;
        1: begin
          if (res_valid && res_idx == 4'd2 && stall < 3) begin
            res_ready = 1'b0; stall++;
          end else begin
            res_ready = 1'b1;
          end
        end
        default: res_ready = 1'($urandom_range(0, 1));
      endcase

      if (cyc == 1) check_eq("busy_rise", 32'(busy), 32'd1);
      if (knn_valid !== prev_mem_en) bad_valid++;
      if (knn_valid && knn_done) bad_overlap++;
      if (knn_solver_sel !== sol) bad_sel++;
      if (mem_en) mem_en_cnt++;
      if (knn_valid) begin
        beats++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (exp_pts.size() > 0) check_eq("point", knn_data_2, exp_pts.pop_front());
      end
      if (knn_done) begin kdone_cnt++; kdone_cyc = cyc; end
      if (prev_rv && !prev_xfer) begin
        if (!res_valid || res_data !== prev_rd || res_idx !== prev_ri) bad_hold++;
      end
      if (res_valid && res_idx == 4'd2) idx2_cycles++;
      if (res_valid && res_ready) begin
        exp_data = core_base + 16'(results);
        check_eq("res_data", 32'(res_data), 32'(exp_data));
        check_eq("res_idx", 32'(res_idx), 32'(results));
        results++;
      end
      if (done) begin
        done_cyc = cyc;
        check_eq("busy_fall", 32'(busy), 32'd0);
        check_eq("busy_before_done", 32'(prev_busy), 32'd1);
      end
      prev_mem_en = mem_en; prev_rv = res_valid; prev_xfer = res_valid && res_ready;
      prev_rd = res_data; prev_ri = res_idx; prev_busy = busy;
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b1;

    check_eq("timeout", 32'(done_cyc >= 0), 32'd1);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("point_beats", 32'(beats), 32'(n));
    check_eq("mem_en_cycles", 32'(mem_en_cnt), 32'(n));
    check_eq("knn_done_count", 32'(kdone_cnt), 32'd1);
    check_eq("result_count", 32'(results), 32'(HW_K));
    check_eq("valid_follows_mem_en", 32'(bad_valid), 32'd0);
    check_eq("valid_done_overlap", 32'(bad_overlap), 32'd0);
    check_eq("solver_sel_hold", 32'(bad_sel), 32'd0);
    check_eq("result_hold", 32'(bad_hold), 32'd0);
    if (n > 0) begin
      check_eq("first_valid_cycle", 32'(first_v), 32'd2);
      check_eq("valid_contiguous", 32'(last_v - first_v + 1), 32'(n));
      check_eq("knn_done_after_last", 32'(kdone_cyc), 32'(last_v + 1));
    end else begin
      check_eq("knn_done_early", 32'(kdone_cyc >= 1 && kdone_cyc <= 2), 32'd1);
    end
    if (n > 0 && rmode != 2) begin
      exp_lat = 4 + n + FLUSH_CYC + 2 * HW_K + ((rmode == 1) ? 3 : 0);
      check_eq("done_latency", 32'(done_cyc), 32'(exp_lat));
    end
    if (rmode == 1) check_eq("rank2_hold_cycles", 32'(idx2_cycles), 32'd4);
  endtask

  task automatic reset_mid_fetch();
    int waited;
    int bad_kdone;
    @(negedge clk);
    n_points = 16'd8; solver_sel = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(mem_en && mem_addr == 16'd2) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("reach_point2", 32'(waited < 20), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ctl", 32'({busy, done, mem_en, knn_valid, knn_done, res_valid}), 32'd0);
    check_eq("abort_addr", 32'(mem_addr), 32'd0);
    check_eq("abort_sel", 32'(knn_sel), 32'd0);
    check_eq("abort_solver", 32'(knn_solver_sel), 32'd0);
    check_eq("abort_res", 32'({res_idx, res_data}), 32'd0);
    rst = 1'b0;
    bad_kdone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (knn_done || busy || mem_en) bad_kdone++;
    end
    check_eq("abort_stays_idle", 32'(bad_kdone), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_points = '0; solver_sel = '0; res_ready = 1'b1;
    core_base = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = {16'(i + 1), 16'(i)};
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", 32'({busy, done, mem_en, knn_valid, knn_done, res_valid}), 32'd0);
    check_eq("reset_addr", 32'(mem_addr), 32'd0);
    check_eq("reset_sel", 32'(knn_sel), 32'd0);
    check_eq("reset_solver", 32'(knn_solver_sel), 32'd0);
    check_eq("reset_res", 32'({res_idx, res_data}), 32'd0);
    rst = 1'b0;

    core_base = 16'($urandom_range(0, 16'hff00));
    do_run(4, 16'd1, 0, 1'b0);
    core_base = 16'($urandom_range(0, 16'hff00));
    do_run(0, 16'd0, 0, 1'b0);
    core_base = 16'd100;
    do_run(6, 16'd1, 1, 1'b0);
    core_base = 16'($urandom_range(0, 16'hff00));
    do_run(5, 16'd1, 0, 1'b1);
    do_run(5, 16'd0, 0, 1'b0);
    reset_mid_fetch();
    do_run(3, 16'd1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      core_base = 16'($urandom_range(0, 16'hff00));
      do_run($urandom_range(1, 40), 16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
